// File: rtl/motor_dicas_seq_if.sv
// Game I/O bundle for the sequential hint engine.
// Master side drives switches/keys, slave side drives displays.
interface motor_dicas_seq_if #(
    parameter int W        = 4,
    parameter int N_FASES  = 2,
    parameter int MAX_TENT = 7
);
    localparam int FW = (N_FASES > 1) ? $clog2(N_FASES) : 1;
    localparam int TW = $clog2(MAX_TENT + 1);

    logic                 inicia;
    logic [N_FASES*W-1:0] senhas;
    logic [W-1:0]         tentativa;
    logic                 confirma;
    logic [6:0]           hex_paridade;
    logic [6:0]           hex_maior_menor;
    logic [W-1:0]         leds_barra;
    logic [FW-1:0]        fase_atual;
    logic [TW-1:0]        tentativas;
    logic                 acertou;
    logic                 vitoria;
    logic                 derrota;

    modport master (
        output inicia, senhas, tentativa, confirma,
        input  hex_paridade, hex_maior_menor, leds_barra,
        input  fase_atual, tentativas, acertou, vitoria, derrota
    );

    modport slave (
        input  inicia, senhas, tentativa, confirma,
        output hex_paridade, hex_maior_menor, leds_barra,
        output fase_atual, tentativas, acertou, vitoria, derrota
    );
endinterface

// File: rtl/motor_dicas_seq.sv
// Sequential password-game hint engine: latches secrets, grades one
// guess per confirma edge, tracks phases, attempts, victory and defeat.
module motor_dicas_seq #(
    parameter int W             = 4,
    parameter int N_FASES       = 2,
    parameter int MAX_TENT      = 7,
    parameter int ACERTO_CICLOS = 50000000
) (
    input logic              clk,
    input logic              reset,
    motor_dicas_seq_if.slave bus
);
    localparam int FW  = (N_FASES > 1) ? $clog2(N_FASES) : 1;
    localparam int TW  = $clog2(MAX_TENT + 1);
    localparam int CW  = $clog2(ACERTO_CICLOS + 1);
    localparam int CNW = $clog2(W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_MAIOR = 7'b1111110;
    localparam logic [6:0] SEG_MENOR = 7'b1110111;
    localparam logic [6:0] SEG_IGUAL = 7'b0110111;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] JOGANDO = 3'd1;
    localparam logic [2:0] AVALIA  = 3'd2;
    localparam logic [2:0] ACERTO  = 3'd3;
    localparam logic [2:0] VITORIA = 3'd4;
    localparam logic [2:0] DERROTA = 3'd5;

    logic [2:0]                  st_q;
    logic [N_FASES-1:0][W-1:0]   sec_q;
    logic [W-1:0]                guess_q;
    logic                        conf_q;
    logic [FW-1:0]               fase_q;
    logic [TW-1:0]               tent_q;
    logic [CW-1:0]               cnt_q;
    logic [W-1:0]                bar_q;
    logic [6:0]                  hex_mm_q;
    logic [6:0]                  hex_par_q;
    logic                        acertou_q;

    logic [W-1:0]   sec_cur;
    logic [CNW-1:0] n_eq;
    logic [W-1:0]   bar_cmp;
    logic [6:0]     hint;
    logic [TW-1:0]  tent_nx;
    logic           hit;
    logic           edge_cf;

    // Grade the registered guess against the current phase secret
    always_comb begin
        sec_cur = sec_q[fase_q];
        hit     = (guess_q == sec_cur);
        edge_cf = bus.confirma & ~conf_q;
        tent_nx = (tent_q == TW'(MAX_TENT)) ? tent_q : tent_q + TW'(1);
        n_eq    = '0;
        for (int i = 0; i < W; i++) begin
            n_eq = n_eq + CNW'(~(guess_q[i] ^ sec_cur[i]));
        end
        bar_cmp = '0;
        for (int i = 0; i < W; i++) begin
            bar_cmp[i] = (CNW'(i) < n_eq);
        end
        hint = SEG_IGUAL;
        unique case (1'b1)
            (guess_q > sec_cur): hint = SEG_MAIOR;
            (guess_q < sec_cur): hint = SEG_MENOR;
            default:             hint = SEG_IGUAL;
        endcase
    end

    // Game state machine and display registers
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= IDLE;
            sec_q     <= '0;
            guess_q   <= '0;
            conf_q    <= 1'b0;
            fase_q    <= '0;
            tent_q    <= '0;
            cnt_q     <= '0;
            bar_q     <= '0;
            hex_mm_q  <= SEG_BLANK;
            hex_par_q <= SEG_BLANK;
            acertou_q <= 1'b0;
        end else begin
            conf_q    <= bus.confirma;
            acertou_q <= 1'b0;
            if (bus.inicia) begin
                sec_q     <= bus.senhas;
                fase_q    <= '0;
                tent_q    <= '0;
                bar_q     <= '0;
                hex_mm_q  <= SEG_BLANK;
                hex_par_q <= (^bus.senhas) ? SEG_ONE : SEG_ZERO;
                st_q      <= JOGANDO;
            end else begin
                case (st_q)
                    JOGANDO: begin
                        if (edge_cf) begin
                            guess_q <= bus.tentativa;
                            st_q    <= AVALIA;
                        end
                    end
                    AVALIA: begin
                        tent_q   <= tent_nx;
                        bar_q    <= bar_cmp;
                        hex_mm_q <= hint;
                        if (hit) begin
                            acertou_q <= 1'b1;
                            cnt_q     <= '0;
                            st_q      <= ACERTO;
                        end else if (tent_nx == TW'(MAX_TENT)) begin
                            bar_q <= '0;
                            st_q  <= DERROTA;
                        end else begin
                            st_q <= JOGANDO;
                        end
                    end
                    ACERTO: begin
                        if (cnt_q == CW'(ACERTO_CICLOS - 1)) begin
                            if (fase_q == FW'(N_FASES - 1)) begin
                                st_q <= VITORIA;
                            end else begin
                                fase_q   <= fase_q + FW'(1);
                                tent_q   <= '0;
                                bar_q    <= '0;
                                hex_mm_q <= SEG_BLANK;
                                st_q     <= JOGANDO;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.hex_paridade    = hex_par_q;
    assign bus.hex_maior_menor = hex_mm_q;
    assign bus.leds_barra      = bar_q;
    assign bus.fase_atual      = fase_q;
    assign bus.tentativas      = tent_q;
    assign bus.acertou         = acertou_q;
    assign bus.vitoria         = (st_q == VITORIA);
    assign bus.derrota         = (st_q == DERROTA);
endmodule

// File: tb/tb_motor_dicas_seq.sv
// Bench for motor_dicas_seq: directed game scenarios plus random games
// graded against a phase/attempt game model.
module tb_motor_dicas_seq;
    localparam int W  = 4;
    localparam int NF = 2;
    localparam int MT = 3;
    localparam int AC = 4;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_ZERO  = 7'b1000000;
    localparam logic [6:0] S_ONE   = 7'b1111001;
    localparam logic [6:0] S_MAIOR = 7'b1111110;
    localparam logic [6:0] S_MENOR = 7'b1110111;
    localparam logic [6:0] S_IGUAL = 7'b0110111;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_WIN  = 2;
    localparam int M_LOSE = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    motor_dicas_seq_if #(.W(W), .N_FASES(NF), .MAX_TENT(MT)) bus ();

    motor_dicas_seq #(
        .W(W), .N_FASES(NF), .MAX_TENT(MT), .ACERTO_CICLOS(AC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_sec [NF];
    int           m_ph;
    int           m_att;
    int           m_st;
    logic [6:0]   m_hint;
    logic [6:0]   m_par;
    logic [W-1:0] m_bar;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] f_hint(input logic [W-1:0] g,
                                          input logic [W-1:0] s);
        if (int'(g) > int'(s)) return S_MAIOR;
        if (int'(g) < int'(s)) return S_MENOR;
        return S_IGUAL;
    endfunction

    function automatic logic [W-1:0] f_bar(input logic [W-1:0] g,
                                           input logic [W-1:0] s);
        int c;
        c = $countones(~(g ^ s));
        return W'((1 << c) - 1);
    endfunction

    task automatic chk_all(input string tag, input logic ac);
        chk({tag, ".par"},  32'(bus.hex_paridade), 32'(m_par));
        chk({tag, ".mm"},   32'(bus.hex_maior_menor), 32'(m_hint));
        chk({tag, ".bar"},  32'(bus.leds_barra), 32'(m_bar));
        chk({tag, ".fase"}, 32'(bus.fase_atual), 32'(m_ph));
        chk({tag, ".tent"}, 32'(bus.tentativas), 32'(m_att));
        chk({tag, ".ac"},   32'(bus.acertou), 32'(ac));
        chk({tag, ".vit"},  32'(bus.vitoria), 32'(m_st == M_WIN));
        chk({tag, ".der"},  32'(bus.derrota), 32'(m_st == M_LOSE));
    endtask

    task automatic model_reset();
        m_ph   = 0;
        m_att  = 0;
        m_st   = M_IDLE;
        m_hint = S_BLANK;
        m_par  = S_BLANK;
        m_bar  = '0;
    endtask

    task automatic do_inicia(input logic [NF*W-1:0] s);
        bus.senhas = s;
        bus.inicia = 1'b1;
        tick();
        bus.inicia = 1'b0;
        bus.senhas = NF*W'($urandom);
        for (int k = 0; k < NF; k++) m_sec[k] = s[k*W +: W];
        m_ph   = 0;
        m_att  = 0;
        m_st   = M_PLAY;
        m_hint = S_BLANK;
        m_bar  = '0;
        m_par  = ($countones(s) % 2 == 1) ? S_ONE : S_ZERO;
        chk_all("ini", 1'b0);
    endtask

    task automatic submit(input logic [W-1:0] g, input int hold);
        bit hit;
        bus.tentativa = g;
        bus.confirma  = 1'b1;
        tick();
        if (hold == 0) bus.confirma = 1'b0;
        bus.tentativa = W'($urandom);
        tick();
        if (m_st != M_PLAY) begin
            chk_all("idle_sub", 1'b0);
        end else begin
            hit    = (g == m_sec[m_ph]);
            m_att  = (m_att < MT) ? m_att + 1 : MT;
            m_hint = f_hint(g, m_sec[m_ph]);
            m_bar  = f_bar(g, m_sec[m_ph]);
            if (hit) begin
                chk_all("hit", 1'b1);
                for (int i = 1; i < AC; i++) begin
                    tick();
                    chk_all("acerto", 1'b0);
                end
                tick();
                if (m_ph < NF - 1) begin
                    m_ph++;
                    m_att  = 0;
                    m_bar  = '0;
                    m_hint = S_BLANK;
                end else begin
                    m_st = M_WIN;
                end
                chk_all("post_hit", 1'b0);
            end else begin
                if (m_att == MT) begin
                    m_st  = M_LOSE;
                    m_bar = '0;
                end
                chk_all("miss", 1'b0);
            end
        end
        if (hold > 0) begin
            repeat (hold) tick();
            chk_all("hold", 1'b0);
            bus.confirma = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.inicia    = 1'b0;
        bus.senhas    = '0;
        bus.tentativa = '0;
        bus.confirma  = 1'b0;
        model_reset();
        tick();
        tick();
        chk_all("reset", 1'b0);
        reset = 1'b0;
        tick();
        chk_all("after_reset", 1'b0);

        do_inicia(8'b0101_1010);
        chk("tp_par", 32'(bus.hex_paridade), 32'(7'b1000000));

        submit(4'b1100, 10);
        chk("tp_mm_maior", 32'(bus.hex_maior_menor), 32'(7'b1111110));
        chk("tp_bar_0011", 32'(bus.leds_barra), 32'(4'b0011));
        chk("tp_tent_1", 32'(bus.tentativas), 32'd1);

        submit(4'b1010, 0);
        chk("tp_fase_1", 32'(bus.fase_atual), 32'd1);

        submit(4'b0000, 0);
        submit(4'b0000, 0);
        submit(4'b0000, 0);
        chk("tp_derrota", 32'(bus.derrota), 32'd1);
        chk("tp_der_mm", 32'(bus.hex_maior_menor), 32'(7'b1110111));
        submit(4'b0101, 0);

        do_inicia(8'b0101_1010);
        submit(4'b1010, 0);
        submit(4'b0000, 0);
        submit(4'b0000, 0);
        submit(4'b0101, 0);
        chk("tp_vitoria", 32'(bus.vitoria), 32'd1);
        chk("tp_no_der", 32'(bus.derrota), 32'd0);
        submit(4'b0000, 0);

        do_inicia(8'b0011_0110);
        submit(4'b0000, 0);
        bus.inicia    = 1'b1;
        bus.senhas    = 8'b0011_0110;
        bus.tentativa = 4'b0110;
        bus.confirma  = 1'b1;
        tick();
        bus.inicia   = 1'b0;
        bus.confirma = 1'b0;
        m_att  = 0;
        m_hint = S_BLANK;
        m_bar  = '0;
        chk_all("ini_conf0", 1'b0);
        tick();
        chk_all("ini_conf1", 1'b0);
        tick();
        chk_all("ini_conf2", 1'b0);

        bus.tentativa = 4'b0110;
        bus.confirma  = 1'b1;
        tick();
        bus.confirma = 1'b0;
        tick();
        chk("rst_pre_ac", 32'(bus.acertou), 32'd1);
        reset = 1'b1;
        tick();
        model_reset();
        chk_all("rst_acerto", 1'b0);
        reset = 1'b0;
        tick();
        chk_all("rst_after", 1'b0);
        submit(4'b0110, 0);

        for (int gm = 0; gm < 10; gm++) begin
            do_inicia(NF*W'($urandom));
            for (int k = 0; k < 8; k++) begin
                logic [W-1:0] g;
                g = ($urandom_range(0, 2) == 0) ? m_sec[m_ph] : W'($urandom);
                submit(g, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/motor_dicas_seq.md
Name: motor_dicas_seq

Overview:
Parametrised, sequential successor to the combinational hint logic of the password game. It latches the N_FASES secrets at game start and accepts one guess per rising edge of `confirma`. Each guess is evaluated in a registered pipeline that drives the parity, higher/lower and progress-bar displays. The block counts attempts per phase, advances phases on a hit, and ends in victory or defeat. It sits between the debounced switch/key inputs and the HEX7/HEX6/LEDR drivers.

Parameters:
W, 4, width of each secret and of the guess.
N_FASES, 2, number of phases (≥2); phase 0 is played first.
MAX_TENT, 7, attempts allowed per phase (≥1).
ACERTO_CICLOS, 50000000, cycles the hit indication is held before the next phase (≥1).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
inicia  in  1  level; start/restart game, latches secrets.
senhas  in  N_FASES*W  packed secrets; phase k = bits [k*W+W-1 : k*W].
tentativa  in  W  current guess (switches).
confirma  in  1  debounced key level; a rising edge submits a guess.
hex_paridade  out  7  active-low 7-seg, parity of all latched secrets.
hex_maior_menor  out  7  active-low 7-seg, higher/lower/equal hint.
leds_barra  out  W  thermometer bar of matching bit positions.
fase_atual  out  max(1,$clog2(N_FASES))  current phase index.
tentativas  out  $clog2(MAX_TENT+1)  attempts used in current phase.
acertou  out  1  one-cycle pulse on each phase hit.
vitoria  out  1  high in VITORIA.
derrota  out  1  high in DERROTA.

Behaviour:
- Segment encodings ({g,f,e,d,c,b,a}, active low): blank 1111111, '0' 1000000, '1' 1111001, MAIOR 1111110 (seg a), MENOR 1110111 (seg d), IGUAL 0110111 (segs d,g).
- Reset state and outputs: IDLE; all hex outputs blank; all other outputs 0; confirma edge register 0.
- States: IDLE, JOGANDO, AVALIA, ACERTO, VITORIA, DERROTA.
- `inicia`, from any state: latch `senhas`; fase_atual=0; tentativas=0; bar=0; hex_maior_menor blank; hex_paridade = XOR-reduce of all latched secret bits ('0' even, '1' odd); next state JOGANDO. `inicia` beats a simultaneous `confirma`.
- Input changes: later changes on `senhas` are ignored until the next `inicia`.
- Edge detection: an edge is `confirma`=1 with previous-cycle `confirma`=0. Holding `confirma` high counts once. Edges outside JOGANDO are ignored, but the edge register always tracks the input.
- JOGANDO, cycle E with an edge: register `tentativa` into a guess register; state becomes AVALIA at E+1.
- AVALIA (one cycle) updates registers visible at E+2, giving 2-cycle latency from edge to display:
  - tentativas increments, saturating at MAX_TENT.
  - leds_barra = thermometer of the count of equal bit positions (count c lights bits [c-1:0]).
  - hex_maior_menor = MAIOR if guess > secret, MENOR if guess < secret, otherwise IGUAL. Comparison is unsigned, W bits.
- AVALIA next state:
  - guess == secret → ACERTO, and acertou pulses for one cycle.
  - guess != secret and new tentativas == MAX_TENT → DERROTA.
  - otherwise → JOGANDO.
  - A hit on the final allowed attempt is a hit, not a defeat.
- ACERTO: leds_barra all ones, hex IGUAL, for exactly ACERTO_CICLOS cycles. Then:
  - if fase_atual < N_FASES-1: fase_atual+1, tentativas=0, bar=0, hex_maior_menor blank, state JOGANDO;
  - else state VITORIA.
- VITORIA: vitoria=1, bar all ones, hex IGUAL; held until `inicia` or reset.
- DERROTA: derrota=1, bar=0, hex_maior_menor keeps the last hint; held until `inicia` or reset.
- Parity: hex_paridade is constant between `inicia` events and blank only in IDLE.
- Reset mid-operation returns to the reset state on the next edge; nothing survives reset.
- The ACERTO counter is width $clog2(ACERTO_CICLOS+1) and clears on entry to ACERTO.

Test Plan:
- Reset, then W=4, N_FASES=2, secrets {ph1=3'... padded 0101, ph0=1010}, pulse inicia: hex_paridade=1000000 (4 ones, even), fase_atual=0, hex_maior_menor blank.
- Phase 0 secret 1010, guess 1100, confirma edge at E: at E+2 hex_maior_menor=1111110, leds_barra=0011, tentativas=1; holding confirma high for 10 cycles leaves tentativas=1.
- Guess 1010, with ACERTO_CICLOS=4: acertou pulses at E+2 (driven in AVALIA); bar=1111 and hex=0110111 for 4 cycles; then fase_atual=1, tentativas=0, bar=0000.
- Phase 1 secret 0101, MAX_TENT=3, wrong guesses 0000, 0000, 0000: third evaluation gives derrota=1, bar=0000, hex_maior_menor=1110111; a further confirma edge leaves everything unchanged.
- Same setup with guesses 0000, 0000, 0101: hit on the final attempt gives ACERTO then VITORIA (vitoria=1), and derrota stays 0.
- `inicia` and a confirma edge in the same cycle mid-phase: state JOGANDO, tentativas=0, no evaluation occurs. Reset asserted during ACERTO gives all outputs at reset values on the next cycle.
